// File: rtl/ahb_pkg.sv
// Shared AHB encodings and responder state type used by the slave responder and its bench.
package ahb_pkg;

    // Bus encodings as plain constants so drivers can use them without casts.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        TransIdle   = HTRANS_IDLE,
        TransBusy   = HTRANS_BUSY,
        TransNonseq = HTRANS_NONSEQ,
        TransSeq    = HTRANS_SEQ
    } htrans_t;

    typedef enum logic [1:0] {
        RespOkay  = HRESP_OKAY,
        RespError = HRESP_ERROR
    } hresp_t;

    // IDLE, WAIT, DATA, ERR1, ERR2 of the responder data-phase sequencer.
    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } resp_state_e;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
    function automatic logic trans_is_active(input htrans_t trans);
        return (trans == TransNonseq) || (trans == TransSeq);
    endfunction

endpackage

// File: rtl/ahb_slave_regfile.sv
// DEPTH x 32 storage: one synchronous write port, one combinational read port, sync clear.
module ahb_slave_regfile #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic        waddr_ok;
    logic        raddr_ok;

    // Indices past DEPTH only exist when DEPTH is not a power of two.
    assign waddr_ok = (32'(waddr_i) < DEPTH);
    assign raddr_ok = (32'(raddr_i) < DEPTH);

    // Storage update: clear everything in reset, otherwise one word per write strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && waddr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read of the addressed word.
    always_comb begin
        rdata_o = '0;
        if (raddr_ok) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/ahb_slave_responder.sv
// AHB slave responder: accepts selected transfers, inserts wait states, returns OKAY or a
// two-cycle ERROR for out-of-range words, and backs the data phase with a small regfile.
module ahb_slave_responder
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [3:0]  BASE_NIBBLE = 4'h8
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata
);

    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  WaitLoad = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    resp_state_e     state_q, state_d;
    resp_state_e     launch_state;
    logic [2:0]      cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            write_q, write_d;

    htrans_t         trans;
    logic            selected;
    logic            in_range;
    logic            slot_free;
    logic            accept;

    hresp_t          resp;
    logic            rf_we;
    logic [31:0]     rf_rdata;

    // Byte lane bits never affect a word-wide slave.
    logic            unused_addr_lsb;
    assign unused_addr_lsb = ^Haddr[1:0];

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    assign trans    = htrans_t'(Htrans);
    assign selected = (Haddr[31:28] == BASE_NIBBLE);
    assign in_range = ({6'd0, Haddr[27:2]} < DEPTH);

    // A new address phase may only be taken while the bus sees Hreadyout=1 from us.
    assign slot_free = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);

    assign accept = Hreadyin && trans_is_active(trans) && selected && slot_free;

    // Where an accepted transfer goes first.
    always_comb begin
        launch_state = StErr1;
        if (in_range) begin
            launch_state = (WAIT_STATES > 0) ? StWait : StData;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // State, wait counter and address-phase latches; reset abandons any transfer.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and wait counter
    // ------------------------------------------------------------------
    // Sequence the data phase; final cycles may chain straight into a pipelined transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StData, StErr2: begin
                state_d = accept ? launch_state : StIdle;
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StErr1: begin
                state_d = StErr2;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (accept && in_range && (WAIT_STATES > 0)) begin
            cnt_d = WaitLoad;
        end
    end

    // Capture index and direction on accept so bus changes cannot disturb the data phase.
    always_comb begin
        idx_d   = idx_q;
        write_d = write_q;
        if (accept) begin
            idx_d   = Haddr[IdxW+1:2];
            write_d = Hwrite;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // Ready/response per state: wait states and ERR1 stall, both error cycles flag ERROR.
    always_comb begin
        Hreadyout = 1'b1;
        resp      = RespOkay;
        unique case (state_q)
            StWait: begin
                Hreadyout = 1'b0;
            end
            StErr1: begin
                Hreadyout = 1'b0;
                resp      = RespError;
            end
            StErr2: begin
                resp      = RespError;
            end
            default: begin
                Hreadyout = 1'b1;
            end
        endcase
    end

    assign Hresp = resp;

    // Storage is only touched in an OKAY write data cycle; errored writes never get here.
    assign rf_we = (state_q == StData) && write_q;

    // Read data is driven only in a read DATA cycle and held at zero otherwise.
    always_comb begin
        Hrdata = '0;
        if ((state_q == StData) && !write_q) begin
            Hrdata = rf_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    ahb_slave_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IdxW)
    ) u_regfile (
        .clk_i   (Hclk),
        .rst_ni  (Hresetn),
        .we_i    (rf_we),
        .waddr_i (idx_q),
        .wdata_i (Hwdata),
        .raddr_i (idx_q),
        .rdata_o (rf_rdata)
    );

endmodule
